inst_seq_mem: RTL and testbench

Parametrised instruction memory and sequencer for a PE. In LOAD mode it stores a program written one instruction per cycle. Each falling edge of the data-valid strobe triggers one or more full passes over the stored program. The block feeds the PE decoder with a registered instruction stream. It adds these capabilities: explicit program length, per-trigger repeat count, queued triggers, and status and error flags.

---
 rtl/inst_seq_mem.sv | 222 ++++++++++++++++++++++
 tb/tb_inst_seq_mem.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_seq_mem.sv
// inst_seq_mem: instruction memory and sequencer feeding a PE decoder.
// A program is loaded one instruction per cycle while idle. Each falling
// edge of data_valid queues a trigger, and each dequeued trigger streams
// the stored program out as a registered instruction stream. Triggers
// queue up to 2**PEND_W-1 deep, and sequences run back to back.
// Optional feature macro: IM_LOOP_EN. When it is defined, rep_cnt selects
// the number of passes per trigger. Without it, every trigger gives a
// single pass.
module inst_seq_mem #(
   parameter int INST_W = 64,
   parameter int ADDR_W = 4,
   parameter int REP_W  = 4,
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_wr,
   input  logic [INST_W-1:0] inst_in,
   input  logic              prog_clr,
   input  logic              data_valid,
   input  logic [REP_W-1:0]  rep_cnt,
   output logic [INST_W-1:0] inst_out,
   output logic              inst_vld,
   output logic [ADDR_W-1:0] pc_out,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   prog_len,
   output logic              wr_full,
   output logic              wr_drop,
   output logic              trig_ovf
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic [ADDR_W:0]     prog_len_q, prog_len_d;
   logic                trig_ovf_q, trig_ovf_d;
   logic                dv_d1_q, dv_d1_d;
   logic                inst_vld_q, inst_vld_d;
   logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
   logic                done_q, done_d;
   logic                wr_drop_q, wr_drop_d;
   logic [INST_W-1:0]   inst_out_q;

   logic                trig;
   logic                mem_we;
   logic                rd_en;
   logic                start;
   logic                deq;
   logic                pass_dec;
   logic                last_pass;
   logic                full;

   // Program storage: one write port, one synchronous read port, no reset.
   logic [INST_W-1:0]   mem [DEPTH];

   assign trig = dv_d1_q & ~data_valid;
   assign full = (prog_len_q == (ADDR_W+1)'(DEPTH));

`ifdef IM_LOOP_EN
   logic [REP_W-1:0] pass_q, pass_d;

   assign last_pass = (pass_q == REP_W'(1));

   // Pass counter: loaded at the start of every sequence, with 0 treated as 1.
   always_comb begin
      pass_d = pass_q;
      if (start)
         pass_d = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
      else if (pass_dec)
         pass_d = pass_q - 1'b1;
   end

   // Pass counter register.
   always_ff @(posedge clk) begin
      if (rst) pass_q <= '0;
      else     pass_q <= pass_d;
   end
`else
   logic loop_unused;

   // Every pass is the final pass, so rep_cnt has no effect.
   assign last_pass   = 1'b1;
   assign loop_unused = ^{rep_cnt, pass_dec};
`endif

   // Sequencer next state, program loading and the trigger queue.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_d     = pend_q;
      prog_len_d = prog_len_q;
      trig_ovf_d = trig_ovf_q;
      dv_d1_d    = data_valid;
      mem_we     = 1'b0;
      rd_en      = 1'b0;
      start      = 1'b0;
      deq        = 1'b0;
      pass_dec   = 1'b0;
      done_d     = 1'b0;
      wr_drop_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (prog_clr) begin
               prog_len_d = '0;
               trig_ovf_d = 1'b0;
            end else if (inst_wr) begin
               if (full) begin
                  wr_drop_d = 1'b1;
               end else begin
                  mem_we     = 1'b1;
                  prog_len_d = prog_len_q + 1'b1;
               end
            end
            // A clear in the same cycle wins over starting on the old program.
            if (pend_q != '0 && prog_len_q != '0 && !prog_clr) begin
               start   = 1'b1;
               deq     = 1'b1;
               pc_d    = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            rd_en     = 1'b1;
            wr_drop_d = inst_wr;
            if ({1'b0, pc_q} == prog_len_q - 1'b1) begin
               pc_d = '0;
               if (last_pass) begin
                  done_d = 1'b1;
                  // A queued trigger chains into a new sequence with no gap.
                  if (pend_q != '0) begin
                     start = 1'b1;
                     deq   = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  pass_dec = 1'b1;
               end
            end else begin
               pc_d = pc_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Without a program, triggers are discarded. Otherwise the queue counts.
      if (state_q == S_IDLE && prog_len_q == '0) begin
         pend_d = '0;
      end else begin
         case ({trig, deq})
            2'b10: begin
               if (pend_q == PEND_MAX) trig_ovf_d = 1'b1;
               else                    pend_d     = pend_q + 1'b1;
            end
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
         endcase
      end
   end

   // Output stage: the read register and its address, valid and done travel together.
   always_comb begin
      inst_vld_d = rd_en;
      pc_out_d   = rd_en ? pc_q : pc_out_q;
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         pend_q     <= '0;
         prog_len_q <= '0;
         trig_ovf_q <= 1'b0;
         dv_d1_q    <= 1'b0;
         inst_vld_q <= 1'b0;
         pc_out_q   <= '0;
         done_q     <= 1'b0;
         wr_drop_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_q     <= pend_d;
         prog_len_q <= prog_len_d;
         trig_ovf_q <= trig_ovf_d;
         dv_d1_q    <= dv_d1_d;
         inst_vld_q <= inst_vld_d;
         pc_out_q   <= pc_out_d;
         done_q     <= done_d;
         wr_drop_q  <= wr_drop_d;
      end
   end

   // Memory write port: this is the only place the array is written.
   always_ff @(posedge clk) begin
      if (mem_we) mem[prog_len_q[ADDR_W-1:0]] <= inst_in;
   end

   // Synchronous read port. It holds its value between runs.
   always_ff @(posedge clk) begin
      if (rst)        inst_out_q <= '0;
      else if (rd_en) inst_out_q <= mem[pc_q];
   end

   assign inst_out = inst_out_q;
   assign inst_vld = inst_vld_q;
   assign pc_out   = pc_out_q;
   assign busy     = (state_q == S_RUN);
   assign done     = done_q;
   assign prog_len = prog_len_q;
   assign wr_full  = full;
   assign wr_drop  = wr_drop_q;
   assign trig_ovf = trig_ovf_q;

endmodule

// File: tb/tb_inst_seq_mem.sv
// Self-checking bench for inst_seq_mem. It uses a vector table for the
// load, clear and reset behaviour, plus directed sequences for the streaming
// corner cases.
module tb_inst_seq_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_wr = 1'b0;
   logic [63:0] inst_in = '0;
   logic        prog_clr = 1'b0;
   logic        data_valid = 1'b0;
   logic [3:0]  rep_cnt = '0;
   logic [63:0] inst_out;
   logic        inst_vld;
   logic [3:0]  pc_out;
   logic        busy;
   logic        done;
   logic [4:0]  prog_len;
   logic        wr_full;
   logic        wr_drop;
   logic        trig_ovf;

   int passed = 0;
   int total  = 0;

`ifdef IM_LOOP_EN
   localparam int LOOP_P = 3;
`else
   localparam int LOOP_P = 1;
`endif

   inst_seq_mem dut (
      .clk(clk), .rst(rst), .inst_wr(inst_wr), .inst_in(inst_in),
      .prog_clr(prog_clr), .data_valid(data_valid), .rep_cnt(rep_cnt),
      .inst_out(inst_out), .inst_vld(inst_vld), .pc_out(pc_out),
      .busy(busy), .done(done), .prog_len(prog_len), .wr_full(wr_full),
      .wr_drop(wr_drop), .trig_ovf(trig_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wr;
      logic        clr;
      logic [63:0] din;
      logic [4:0]  len;
      logic        full;
      logic        drop;
   } vec_t;

   vec_t tv[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; step(); rst = 1'b0;
   endtask

   task automatic wr(input logic [63:0] d);
      inst_wr = 1'b1; inst_in = d; step(); inst_wr = 1'b0;
   endtask

   // One-cycle high pulse. The trigger is sampled on the second edge (E0).
   task automatic trig_pulse();
      data_valid = 1'b1; step(); data_valid = 1'b0; step();
   endtask

   initial begin
      int cnt, dn, gaps, errs;
      bit seen;

      tv[0] = '{1'b1, 1'b0, 1'b0, 64'h0,  5'd0, 1'b0, 1'b0};
      tv[1] = '{1'b0, 1'b1, 1'b0, 64'hA1, 5'd1, 1'b0, 1'b0};
      tv[2] = '{1'b0, 1'b1, 1'b0, 64'hA2, 5'd2, 1'b0, 1'b0};
      tv[3] = '{1'b0, 1'b1, 1'b1, 64'hA3, 5'd0, 1'b0, 1'b0};
      tv[4] = '{1'b0, 1'b1, 1'b0, 64'hB1, 5'd1, 1'b0, 1'b0};
      tv[5] = '{1'b0, 1'b0, 1'b1, 64'h0,  5'd0, 1'b0, 1'b0};
      tv[6] = '{1'b0, 1'b0, 1'b0, 64'h0,  5'd0, 1'b0, 1'b0};
      tv[7] = '{1'b0, 1'b1, 1'b0, 64'hC1, 5'd1, 1'b0, 1'b0};

      // Reset state
      step(); step();
      rst = 1'b0;
      chk("rst_inst_out", inst_out, 0);
      chk("rst_vld", inst_vld, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_len", prog_len, 0);
      chk("rst_full", wr_full, 0);
      chk("rst_drop", wr_drop, 0);
      chk("rst_ovf", trig_ovf, 0);

      // Table: load, clear priority and reset
      for (int i = 0; i < 8; i++) begin
         rst = tv[i].rst; inst_wr = tv[i].wr; prog_clr = tv[i].clr; inst_in = tv[i].din;
         step();
         chk($sformatf("tv%0d_len", i), prog_len, tv[i].len);
         chk($sformatf("tv%0d_full", i), wr_full, tv[i].full);
         chk($sformatf("tv%0d_drop", i), wr_drop, tv[i].drop);
      end
      rst = 1'b0; inst_wr = 1'b0; prog_clr = 1'b0;

      // Basic 5-instruction run with a 3-cycle data_valid pulse
      do_reset();
      for (int i = 0; i < 5; i++) wr(64'h11 + i);
      chk("t1_len", prog_len, 5);
      data_valid = 1'b1; step(); step(); step();
      data_valid = 1'b0; step();               // E0
      chk("t1_vld_e0", inst_vld, 0);
      step();                                  // E1
      chk("t1_busy_e1", busy, 1);
      chk("t1_vld_e1", inst_vld, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("t1_vld%0d", i), inst_vld, 1);
         chk($sformatf("t1_out%0d", i), inst_out, 64'h11 + i);
         chk($sformatf("t1_pc%0d", i), pc_out, i);
         chk($sformatf("t1_done%0d", i), done, (i == 4));
         chk($sformatf("t1_busy%0d", i), busy, (i != 4));
      end
      step();
      chk("t1_vld_end", inst_vld, 0);
      chk("t1_busy_end", busy, 0);
      chk("t1_done_end", done, 0);

      // Write during RUN is dropped, and the program is unchanged
      trig_pulse(); step();                    // E1, busy
      inst_wr = 1'b1; inst_in = 64'hDEAD; step(); inst_wr = 1'b0;
      chk("t4_run_drop", wr_drop, 1);
      chk("t4_run_out0", inst_out, 64'h11);
      for (int i = 1; i < 5; i++) begin
         step();
         chk($sformatf("t4_run_out%0d", i), inst_out, 64'h11 + i);
      end
      step();
      chk("t4_run_len", prog_len, 5);
      chk("t4_drop_clear", wr_drop, 0);

      // Loop passes
      do_reset();
      for (int i = 0; i < 4; i++) wr(64'h21 + i);
      rep_cnt = 4'd3;
      trig_pulse(); step();
      errs = 0; dn = 0;
      for (int k = 0; k < LOOP_P * 4; k++) begin
         step();
         if (inst_vld !== 1'b1 || pc_out !== 4'(k % 4) || inst_out !== 64'h21 + 64'(k % 4)) errs++;
         if (done === 1'b1) dn++;
      end
      chk("t2_stream_errs", errs, 0);
      chk("t2_last_done", done, 1);
      chk("t2_done_count", dn, 1);
      step();
      chk("t2_vld_after", inst_vld, 0);
      chk("t2_busy_after", busy, 0);
      rep_cnt = 4'd0;

      // Trigger queue overflow with back-to-back sequences
      do_reset();
      for (int i = 0; i < 16; i++) wr(64'h100 + i);
      trig_pulse();                            // E0
      cnt = 0; dn = 0; gaps = 0; errs = 0; seen = 0;
      for (int c = 0; c < 100; c++) begin
         data_valid = (c < 8) && (c % 2 == 1);
         step();
         if (inst_vld === 1'b1) begin
            seen = 1;
            if (pc_out !== 4'(cnt % 16) || inst_out !== 64'h100 + 64'(cnt % 16)) errs++;
            cnt++;
         end else if (seen && cnt < 64) begin
            gaps++;
         end
         if (done === 1'b1) dn++;
      end
      chk("t3_vld_cycles", cnt, 64);
      chk("t3_gaps", gaps, 0);
      chk("t3_pc_errs", errs, 0);
      chk("t3_done_count", dn, 4);
      chk("t3_ovf", trig_ovf, 1);
      chk("t3_busy_end", busy, 0);
      prog_clr = 1'b1; step(); prog_clr = 1'b0;
      chk("t3_ovf_clr", trig_ovf, 0);
      chk("t3_len_clr", prog_len, 0);

      // Full program and a 17th write
      do_reset();
      for (int i = 0; i < 16; i++) wr(64'h200 + i);
      chk("t4_full", wr_full, 1);
      chk("t4_len16", prog_len, 16);
      chk("t4_nodrop", wr_drop, 0);
      wr(64'h2FF);
      chk("t4_drop", wr_drop, 1);
      chk("t4_len_keep", prog_len, 16);
      step();
      chk("t4_drop_pulse", wr_drop, 0);

      // Trigger with an empty program
      do_reset();
      trig_pulse();
      errs = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (busy !== 1'b0 || inst_vld !== 1'b0) errs++;
      end
      chk("t5_empty_idle", errs, 0);

      // Reset in the 3rd cycle of a run
      do_reset();
      for (int i = 0; i < 5; i++) wr(64'h31 + i);
      trig_pulse(); step(); step(); step();    // E1..E3
      chk("t6_running", inst_vld, 1);
      rst = 1'b1; step(); rst = 1'b0;
      chk("t6_out", inst_out, 0);
      chk("t6_vld", inst_vld, 0);
      chk("t6_pc", pc_out, 0);
      chk("t6_busy", busy, 0);
      chk("t6_len", prog_len, 0);
      errs = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (done !== 1'b0 || inst_vld !== 1'b0 || busy !== 1'b0) errs++;
      end
      chk("t6_no_done", errs, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
